// File: rtl/l1_cache_line.sv
// Direct-mapped, write-through, no-write-allocate L1 cache between a CPU port and an SDRAM controller.
// Addresses at or above CACHE_LIMIT bypass the cache combinationally while the FSM is idle.
module l1_cache_line #(
  parameter int          INDEX_BITS  = 8,
  parameter int          OFFSET_BITS = 2,
  parameter int          ADDR_BITS   = 24,
  parameter logic [31:0] CACHE_LIMIT = 32'h800000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cache_reset,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_data,
  input  logic        cpu_we,
  input  logic        cpu_start,
  output logic [31:0] cpu_q,
  output logic        cpu_done,
  output logic [31:0] sdc_addr,
  output logic [31:0] sdc_data,
  output logic        sdc_we,
  output logic        sdc_start,
  input  logic [31:0] sdc_q,
  input  logic        sdc_done
);

  localparam int TAG_BITS = ADDR_BITS - INDEX_BITS - OFFSET_BITS;
  localparam int LINES    = 1 << INDEX_BITS;
  localparam int DEPTH    = 1 << (INDEX_BITS + OFFSET_BITS);

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_CHECK, S_FILL_REQ, S_FILL_WAIT, S_WRITE
  } state_t;

  state_t state, state_nxt;

  logic [31:0]            req_addr, req_addr_nxt;
  logic [31:0]            req_data, req_data_nxt;
  logic                   req_we, req_we_nxt;
  logic                   start_prev;
  logic [31:0]            addr_prev;
  logic [OFFSET_BITS-1:0] cnt, cnt_nxt;
  logic                   fill_abort, fill_abort_nxt;
  logic [LINES-1:0]       valid;

  logic [31:0] cpu_q_r, cpu_q_nxt;
  logic        cpu_done_r, cpu_done_nxt;
  logic [31:0] sdc_addr_r, sdc_addr_nxt;
  logic [31:0] sdc_data_r, sdc_data_nxt;
  logic        sdc_we_r, sdc_we_nxt;
  logic        sdc_start_r, sdc_start_nxt;

  logic [TAG_BITS-1:0] tag_mem  [LINES];
  logic [31:0]         data_mem [DEPTH];
  logic [TAG_BITS-1:0] rd_tag;
  logic [31:0]         rd_word;

  logic                              data_we;
  logic [INDEX_BITS+OFFSET_BITS-1:0] data_waddr;
  logic [31:0]                       data_wdata;
  logic                              tag_we;
  logic                              set_valid;
  logic                              clr_valid;

  logic [OFFSET_BITS-1:0] req_off;
  logic [INDEX_BITS-1:0]  req_idx;
  logic [TAG_BITS-1:0]    req_tag;
  logic                   bypass;
  logic                   accept;
  logic                   hit;

  assign req_off = req_addr[OFFSET_BITS-1:0];
  assign req_idx = req_addr[OFFSET_BITS +: INDEX_BITS];
  assign req_tag = req_addr[OFFSET_BITS+INDEX_BITS +: TAG_BITS];

  assign bypass = (state == S_IDLE) && (cpu_addr >= CACHE_LIMIT);
  // A held strobe only re-arms when the previous cycle was an uncached access.
  assign accept = (state == S_IDLE) && (cpu_addr < CACHE_LIMIT) && cpu_start &&
                  (!start_prev || (addr_prev >= CACHE_LIMIT));
  assign hit    = valid[req_idx] && (rd_tag == req_tag);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      req_addr    <= '0;
      req_data    <= '0;
      req_we      <= 1'b0;
      start_prev  <= 1'b0;
      addr_prev   <= '0;
      cnt         <= '0;
      fill_abort  <= 1'b0;
      cpu_q_r     <= '0;
      cpu_done_r  <= 1'b0;
      sdc_addr_r  <= '0;
      sdc_data_r  <= '0;
      sdc_we_r    <= 1'b0;
      sdc_start_r <= 1'b0;
    end else begin
      state       <= state_nxt;
      req_addr    <= req_addr_nxt;
      req_data    <= req_data_nxt;
      req_we      <= req_we_nxt;
      start_prev  <= cpu_start;
      addr_prev   <= cpu_addr;
      cnt         <= cnt_nxt;
      fill_abort  <= fill_abort_nxt;
      cpu_q_r     <= cpu_q_nxt;
      cpu_done_r  <= cpu_done_nxt;
      sdc_addr_r  <= sdc_addr_nxt;
      sdc_data_r  <= sdc_data_nxt;
      sdc_we_r    <= sdc_we_nxt;
      sdc_start_r <= sdc_start_nxt;
    end
  end

  // Invalidation beats a same-cycle fill completion.
  always_ff @(posedge clk) begin
    if (reset || cache_reset) begin
      valid <= '0;
    end else begin
      if (clr_valid) valid[req_idx] <= 1'b0;
      if (set_valid) valid[req_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (data_we) data_mem[data_waddr] <= data_wdata;
    if (tag_we)  tag_mem[req_idx]     <= req_tag;
    rd_word <= data_mem[{req_idx, req_off}];
    rd_tag  <= tag_mem[req_idx];
  end

  always_comb begin
    state_nxt      = state;
    req_addr_nxt   = req_addr;
    req_data_nxt   = req_data;
    req_we_nxt     = req_we;
    cnt_nxt        = cnt;
    fill_abort_nxt = fill_abort | cache_reset;
    cpu_q_nxt      = cpu_q_r;
    cpu_done_nxt   = 1'b0;
    sdc_addr_nxt   = sdc_addr_r;
    sdc_data_nxt   = sdc_data_r;
    sdc_we_nxt     = sdc_we_r;
    sdc_start_nxt  = sdc_start_r;
    data_we        = 1'b0;
    data_waddr     = {req_idx, req_off};
    data_wdata     = req_data;
    tag_we         = 1'b0;
    set_valid      = 1'b0;
    clr_valid      = 1'b0;

    case (state)
      S_IDLE: begin
        sdc_start_nxt = 1'b0;
        if (accept) begin
          req_addr_nxt = cpu_addr;
          req_data_nxt = cpu_data;
          req_we_nxt   = cpu_we;
          state_nxt    = S_LOOKUP;
        end
      end
      S_LOOKUP: state_nxt = S_CHECK;
      S_CHECK: begin
        if (req_we) begin
          data_we       = hit;
          sdc_start_nxt = 1'b1;
          sdc_we_nxt    = 1'b1;
          sdc_addr_nxt  = req_addr;
          sdc_data_nxt  = req_data;
          state_nxt     = S_WRITE;
        end else if (hit) begin
          cpu_q_nxt    = rd_word;
          cpu_done_nxt = 1'b1;
          state_nxt    = S_IDLE;
        end else begin
          cnt_nxt        = '0;
          fill_abort_nxt = cache_reset;
          clr_valid      = 1'b1;
          sdc_we_nxt     = 1'b0;
          sdc_data_nxt   = '0;
          state_nxt      = S_FILL_REQ;
        end
      end
      S_FILL_REQ: begin
        sdc_start_nxt = 1'b1;
        sdc_we_nxt    = 1'b0;
        sdc_data_nxt  = '0;
        sdc_addr_nxt  = {req_addr[31:OFFSET_BITS], cnt};
        state_nxt     = S_FILL_WAIT;
      end
      S_FILL_WAIT: begin
        if (sdc_done) begin
          sdc_start_nxt = 1'b0;
          data_we       = 1'b1;
          data_waddr    = {req_idx, cnt};
          data_wdata    = sdc_q;
          cnt_nxt       = cnt + 1'b1;
          if (cnt == req_off) cpu_q_nxt = sdc_q;
          if (&cnt) begin
            tag_we       = 1'b1;
            set_valid    = !fill_abort && !cache_reset;
            cpu_done_nxt = 1'b1;
            state_nxt    = S_IDLE;
          end else begin
            state_nxt = S_FILL_REQ;
          end
        end
      end
      S_WRITE: begin
        if (sdc_done) begin
          sdc_start_nxt = 1'b0;
          sdc_we_nxt    = 1'b0;
          cpu_done_nxt  = 1'b1;
          state_nxt     = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign sdc_addr  = bypass ? cpu_addr  : sdc_addr_r;
  assign sdc_data  = bypass ? cpu_data  : sdc_data_r;
  assign sdc_we    = bypass ? cpu_we    : sdc_we_r;
  assign sdc_start = bypass ? cpu_start : sdc_start_r;
  assign cpu_q     = bypass ? sdc_q     : cpu_q_r;
  assign cpu_done  = bypass ? sdc_done  : cpu_done_r;

endmodule

// File: doc/l1_cache_line.md
L1_CACHE_LINE -- requirements
Module: l1_cache_line

Interface
REQ-001 SHALL have parameter INDEX_BITS, default 8, meaning log2 of line count.
REQ-002 SHALL have parameter OFFSET_BITS, default 2, meaning log2 of words per line (1..3).
REQ-003 SHALL have parameter ADDR_BITS, default 24, meaning cacheable word-address width; tag = ADDR_BITS-INDEX_BITS-OFFSET_BITS.
REQ-004 SHALL have parameter CACHE_LIMIT, default 32'h800000, meaning addresses >= this bypass the cache.
REQ-005 SHALL have ports, one per line (clock and reset first):
 clk  in  1  clock, all logic on rising edge
 reset  in  1  synchronous, active-high
 cache_reset  in  1  invalidate all lines, synchronous
 cpu_addr  in  32  word address
 cpu_data  in  32  write data
 cpu_we  in  1  write request
 cpu_start  in  1  request strobe, held until cpu_done
 cpu_q  out  32  read data
 cpu_done  out  1  one-cycle completion pulse
 sdc_addr  out  32  SDRAM word address
 sdc_data  out  32  SDRAM write data
 sdc_we  out  1  SDRAM write
 sdc_start  out  1  SDRAM request, held until sdc_done
 sdc_q  in  32  SDRAM read data
 sdc_done  in  1  SDRAM completion pulse
REQ-006 Reset SHALL be reset, synchronous, active-high; clock SHALL be clk.

Function
REQ-007 Organisation SHALL be direct-mapped, 2^INDEX_BITS lines of 2^OFFSET_BITS words, write-through, no-write-allocate; tag/data arrays synchronous-read (1-cycle latency), valid bits in registers.
REQ-008 Address split: offset = cpu_addr[OFFSET_BITS-1:0], index = next INDEX_BITS, tag = bits up to ADDR_BITS-1.
REQ-009 Bypass: when cpu_addr >= CACHE_LIMIT, sdc_* SHALL combinationally follow cpu_* and cpu_q/cpu_done follow sdc_q/sdc_done; FSM stays IDLE.
REQ-010 Acceptance: in IDLE with cpu_addr < CACHE_LIMIT, request accepted when cpu_start && (!start_prev || addr_prev >= CACHE_LIMIT); address, data, we latched; later cpu_addr changes ignored until done.
REQ-011 States: IDLE, LOOKUP, CHECK, FILL_REQ, FILL_WAIT, WRITE.
REQ-012 Read: IDLE->LOOKUP (array read)->CHECK; hit (valid && tag match) -> cpu_q = stored word, cpu_done pulse, IDLE; hit latency 3 cycles from acceptance to cpu_done.
REQ-013 Read miss: CHECK->FILL_REQ; fill words SHALL be fetched sequentially from offset 0 to 2^OFFSET_BITS-1 at line base address.
REQ-014 FILL_REQ asserts sdc_start, sdc_we=0, sdc_addr=line base+word counter; FILL_WAIT holds until sdc_done, writes sdc_q into data array at counter, deasserts sdc_start for at least one cycle, increments counter.
REQ-015 After last word: tag written, valid set, cpu_q = requested word, cpu_done pulse same cycle, IDLE.
REQ-016 Write: IDLE->WRITE, sdc_start=1, sdc_we=1, sdc_addr/sdc_data latched; on sdc_done cpu_done pulses, sdc_start drops, IDLE.
REQ-017 Write hit (valid, tag match, checked via LOOKUP before SDRAM issue) SHALL update that word in the array, valid unchanged; write miss SHALL not touch arrays.
REQ-018 cache_reset SHALL clear all valid bits next edge; if asserted during FILL, the filling line SHALL NOT become valid but the CPU read still completes with correct data.
REQ-019 cache_reset and a same-cycle valid set: clear wins.
REQ-020 cpu_done SHALL never exceed one cycle per accepted request; no new request accepted outside IDLE.
REQ-021 While cached path owns the bus, sdc_data = 0 during reads and sdc_start = 0 in IDLE, LOOKUP, CHECK.

Reset
REQ-022 On reset: state IDLE, all valid bits 0, cpu_done 0, cpu_q 0, sdc_start 0, sdc_we 0, sdc_addr 0, sdc_data 0, start_prev 0, addr_prev 0, counter 0.
REQ-023 Reset mid-FILL or mid-WRITE SHALL abort: sdc_start low next cycle, no cpu_done, line left invalid.

Verification
REQ-024 Cold read 0x000104 (defaults), SDRAM mem[a]=a -> four sdc reads 0x104..0x107, cpu_q=0x104, cpu_done once; reread 0x000106 -> cpu_q=0x106, 3-cycle hit, no sdc_start.
REQ-025 Write 0xDEAD to 0x000105 after REQ-024 fill -> one sdc write, then read 0x000105 -> hit, 0xDEAD; write 0x1 to uncached 0x002000 -> line 0x002000 stays invalid.
REQ-026 Conflict: read 0x000104 then 0x000504 (same index, tag differs) -> second misses, refills; re-read 0x000104 misses again.
REQ-027 Bypass: read 0x800010 -> sdc_addr=0x800010 same cycle, cpu_done mirrors sdc_done, no array change; back-to-back cached read with cpu_start held high accepted.
REQ-028 cache_reset pulse during second fill word of 0x000200 -> cpu_q correct, subsequent read of 0x000200 misses; reset mid-fill -> sdc_start low next cycle, no cpu_done.
